hdmi_align_ctrl: RTL and testbench
==================================

# hdmi_align_ctrl

Alignment controller for the HDMI receive path. Sweeps the word-phase select (0..9) and PLL fine-delay tap (0..15) that drive the deserializer, scores each setting by counting TMDS control words seen on channel 0, applies the best-scoring setting, then monitors it and rescans on loss. Sits in the pixel-clock domain between `hdmi_raw` (consumes its `d0` and PLL lock) and the phase/`pll_delay` inputs it replaces.

## Interface

- `WINDOW_BITS`, 12: measurement window is 2^WINDOW_BITS cycles per setting.
- `SETTLE_CYCLES`, 64: cycles ignored after any phase/delay change (pipeline + clock-cross flush).
- `LOSS_BITS`, 18: cycles without a control word in TRACK before loss is declared is 2^LOSS_BITS.
- `MIN_HITS`, 16: minimum best score accepted; below it the scan repeats.
- `NUM_DELAYS`, 16: delay taps swept, 1..16.

- `clk`  in  1  pixel clock (TMDS clock from the global buffer).
- `reset_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  PLL lock; low forces IDLE.
- `d0`  in  10  raw 10-bit channel-0 word, new value every cycle.
- `phase`  out  4  word-phase select to the clock crosser, 0..9.
- `pll_delay`  out  4  PLL fine-delay tap, 0..NUM_DELAYS-1.
- `aligned`  out  1  high only in TRACK.
- `scanning`  out  1  high in SETTLE, MEASURE, NEXT.
- `best_score`  out  WINDOW_BITS+1  hit count of the applied setting, held until next scan completes.
- `rescans`  out  8  count of scans that failed or ended in loss; saturates at 255.

## Operation

- Control-word match: `d0` equal to any of 10'h354, 10'h0AB, 10'h154, 10'h2AB, registered into `hit` (1 cycle).
- States: IDLE, SETTLE, MEASURE, NEXT, APPLY, TRACK.
- IDLE: `phase`=0, `pll_delay`=0, best cleared. When `pll_locked`=1, go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then clear hit counter, go to MEASURE.
- MEASURE: for exactly 2^WINDOW_BITS cycles add `hit` to a WINDOW_BITS+1-bit counter (cannot overflow), then go to NEXT.
- NEXT (1 cycle): if count > best (strict), store count and current phase/delay as best. Advance phase-inner, delay-outer: phase 9 wraps to 0 and increments delay. After phase 9 with delay NUM_DELAYS-1, go to APPLY; otherwise go to SETTLE.
- APPLY: if best ≥ MIN_HITS, drive best phase/delay, update `best_score`, wait SETTLE_CYCLES, go to TRACK. Otherwise increment `rescans` and go to IDLE.
- TRACK: loss counter cleared on every `hit`. At 2^LOSS_BITS cycles without a hit, increment `rescans` and go to IDLE.
- Ties: the first setting in scan order wins (lowest delay, then lowest phase).
- `pll_locked` low in any state: next state IDLE. `aligned` and `scanning` drop in the same cycle that IDLE is entered. No count is stored.

## Timing

- Reset values: `phase`=0, `pll_delay`=0, `aligned`=0, `scanning`=0, `best_score`=0, `rescans`=0, state IDLE, all counters 0.
- All outputs are registered. A phase or delay change is visible the cycle after NEXT or APPLY.
- `hit` lags `d0` by 1 cycle. The MEASURE window samples `hit` for cycles 1..2^WINDOW_BITS after entry.
- Cycles per setting: SETTLE_CYCLES + 2^WINDOW_BITS + 1 (NEXT).
- Full scan: 10·NUM_DELAYS settings, then APPLY adds SETTLE_CYCLES + 1.
- `aligned` rises in the first TRACK cycle and falls in the cycle after loss or `pll_locked` low is detected.
- A `hit` in the same cycle the loss counter reaches terminal count takes priority: counter clears, no loss.
- `rescans` saturates at 255 with no wrap.

## Test plan

Benches use WINDOW_BITS=4, SETTLE_CYCLES=4, LOSS_BITS=6, MIN_HITS=2, NUM_DELAYS=2.

- Reset and idle: `reset_n`=0, then 1 with `pll_locked`=0 for 100 cycles. Required: all outputs stay at reset values, state remains IDLE.
- Single good setting: model emits 10'h2AB every 2nd cycle only when phase=7, delay=1, else 10'h000. Required: after 20 settings, `phase`=7, `pll_delay`=1, `best_score`=8, `aligned`=1.
- Tie: phase 3/delay 0 and phase 5/delay 1 both give 8 hits. Required: applied setting is phase 3, delay 0.
- Failed scan: every setting gives at most 1 hit. Required: `rescans` increments to 1, `aligned` stays 0, and a new scan restarts from phase 0/delay 0.
- Loss in TRACK: after alignment, stop control words for 64 cycles. Required: `aligned` falls, `rescans`+1, rescan begins. A hit at cycle 63 instead keeps `aligned`=1.
- Lock drop mid-MEASURE: drop `pll_locked` for 1 cycle. Required: IDLE next cycle, `phase`=`pll_delay`=0, `scanning`=0, and the scan restarts on relock. Assert `reset_n` mid-TRACK: outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/hdmi_align_ctrl.sv
// Word-phase / PLL fine-delay alignment controller for the HDMI channel-0 receive path.
// Sweeps every phase/delay pair, scores TMDS control words, applies the best and tracks it.
module hdmi_align_ctrl #(
  parameter int WINDOW_BITS   = 12,
  parameter int SETTLE_CYCLES = 64,
  parameter int LOSS_BITS     = 18,
  parameter int MIN_HITS      = 16,
  parameter int NUM_DELAYS    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic [9:0]             d0,
  output logic [3:0]             phase,
  output logic [3:0]             pll_delay,
  output logic                   aligned,
  output logic                   scanning,
  output logic [WINDOW_BITS:0]   best_score,
  output logic [7:0]             rescans
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [SW-1:0]          SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]          SETTLE_FULL = SW'(SETTLE_CYCLES);
  localparam logic [WINDOW_BITS-1:0] WIN_LAST    = '1;
  localparam logic [LOSS_BITS-1:0]   LOSS_LAST   = '1;
  localparam logic [WINDOW_BITS:0]   MIN_SCORE   = (WINDOW_BITS + 1)'(MIN_HITS);
  localparam logic [3:0]             LAST_DELAY  = 4'(NUM_DELAYS - 1);
  localparam logic [3:0]             LAST_PHASE  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_NEXT,
    S_APPLY,
    S_TRACK
  } state_t;

  state_t                 state_q, state_d;
  logic                   hit_q, hit_d;
  logic [SW-1:0]          settle_cnt_q, settle_cnt_d;
  logic [WINDOW_BITS-1:0] win_cnt_q, win_cnt_d;
  logic [WINDOW_BITS:0]   score_q, score_d;
  logic [WINDOW_BITS:0]   best_q, best_d;
  logic [3:0]             best_phase_q, best_phase_d;
  logic [3:0]             best_delay_q, best_delay_d;
  logic [LOSS_BITS-1:0]   loss_cnt_q, loss_cnt_d;
  logic [3:0]             phase_q, phase_d;
  logic [3:0]             delay_q, delay_d;
  logic                   aligned_q, aligned_d;
  logic                   scanning_q, scanning_d;
  logic [WINDOW_BITS:0]   best_score_q, best_score_d;
  logic [7:0]             rescans_q, rescans_d;
  logic                   rescan_inc;

  // The four TMDS control tokens; registering the match is the one-cycle hit lag.
  always_comb begin
    hit_d = (d0 == 10'h354) || (d0 == 10'h0AB) || (d0 == 10'h154) || (d0 == 10'h2AB);
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    score_d      = score_q;
    best_d       = best_q;
    best_phase_d = best_phase_q;
    best_delay_d = best_delay_q;
    loss_cnt_d   = loss_cnt_q;
    phase_d      = phase_q;
    delay_d      = delay_q;
    best_score_d = best_score_q;
    rescans_d    = rescans_q;
    rescan_inc   = 1'b0;

    if (!pll_locked) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          best_d       = '0;
          best_phase_d = '0;
          best_delay_d = '0;
          state_d      = S_SETTLE;
        end

        S_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_d = '0;
            win_cnt_d    = '0;
            score_d      = '0;
            state_d      = S_MEASURE;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end

        S_MEASURE: begin
          score_d   = score_q + (WINDOW_BITS + 1)'(hit_q);
          win_cnt_d = win_cnt_q + 1'b1;
          if (win_cnt_q == WIN_LAST) begin
            state_d = S_NEXT;
          end
        end

        S_NEXT: begin
          // Strict compare keeps the earliest setting in scan order on a tie.
          if (score_q > best_q) begin
            best_d       = score_q;
            best_phase_d = phase_q;
            best_delay_d = delay_q;
          end
          settle_cnt_d = '0;
          if (phase_q == LAST_PHASE) begin
            phase_d = '0;
            if (delay_q == LAST_DELAY) begin
              delay_d = '0;
              state_d = S_APPLY;
            end else begin
              delay_d = delay_q + 1'b1;
              state_d = S_SETTLE;
            end
          end else begin
            phase_d = phase_q + 1'b1;
            state_d = S_SETTLE;
          end
        end

        S_APPLY: begin
          // Count 0 decides; counts 1..SETTLE_CYCLES flush the new setting.
          if (settle_cnt_q == '0) begin
            if (best_q >= MIN_SCORE) begin
              phase_d      = best_phase_q;
              delay_d      = best_delay_q;
              best_score_d = best_q;
              settle_cnt_d = settle_cnt_q + 1'b1;
            end else begin
              rescan_inc = 1'b1;
              state_d    = S_IDLE;
            end
          end else if (settle_cnt_q == SETTLE_FULL) begin
            settle_cnt_d = '0;
            loss_cnt_d   = '0;
            state_d      = S_TRACK;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end

        S_TRACK: begin
          if (hit_q) begin
            loss_cnt_d = '0;
          end else if (loss_cnt_q == LOSS_LAST) begin
            rescan_inc = 1'b1;
            state_d    = S_IDLE;
          end else begin
            loss_cnt_d = loss_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (state_d == S_IDLE) begin
      phase_d      = '0;
      delay_d      = '0;
      settle_cnt_d = '0;
      win_cnt_d    = '0;
      loss_cnt_d   = '0;
    end

    if (rescan_inc && (rescans_q != 8'hFF)) begin
      rescans_d = rescans_q + 8'd1;
    end

    aligned_d  = (state_d == S_TRACK);
    scanning_d = (state_d == S_SETTLE) || (state_d == S_MEASURE) || (state_d == S_NEXT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      hit_q        <= 1'b0;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      score_q      <= '0;
      best_q       <= '0;
      best_phase_q <= '0;
      best_delay_q <= '0;
      loss_cnt_q   <= '0;
      phase_q      <= '0;
      delay_q      <= '0;
      aligned_q    <= 1'b0;
      scanning_q   <= 1'b0;
      best_score_q <= '0;
      rescans_q    <= '0;
    end else begin
      state_q      <= state_d;
      hit_q        <= hit_d;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      score_q      <= score_d;
      best_q       <= best_d;
      best_phase_q <= best_phase_d;
      best_delay_q <= best_delay_d;
      loss_cnt_q   <= loss_cnt_d;
      phase_q      <= phase_d;
      delay_q      <= delay_d;
      aligned_q    <= aligned_d;
      scanning_q   <= scanning_d;
      best_score_q <= best_score_d;
      rescans_q    <= rescans_d;
    end
  end

  assign phase      = phase_q;
  assign pll_delay  = delay_q;
  assign aligned    = aligned_q;
  assign scanning   = scanning_q;
  assign best_score = best_score_q;
  assign rescans    = rescans_q;

endmodule

// File: tb/tb_hdmi_align_ctrl.sv
// Directed bench for hdmi_align_ctrl with a small channel-0 word model keyed on phase/delay.
// Cycle numbers are counted in edges after reset release (or after relock).
module tb_hdmi_align_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic [9:0] d0 = 10'h000;
  logic [3:0] phase;
  logic [3:0] pll_delay;
  logic       aligned;
  logic       scanning;
  logic [4:0] best_score;
  logic [7:0] rescans;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         mode = 0;
  logic       manual = 1'b0;
  logic [9:0] man_d0 = 10'h000;

  hdmi_align_ctrl #(
    .WINDOW_BITS  (4),
    .SETTLE_CYCLES(4),
    .LOSS_BITS    (6),
    .MIN_HITS     (2),
    .NUM_DELAYS   (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .d0        (d0),
    .phase     (phase),
    .pll_delay (pll_delay),
    .aligned   (aligned),
    .scanning  (scanning),
    .best_score(best_score),
    .rescans   (rescans)
  );

  always #5 clk = ~clk;

  // 1: single good setting 7/1; 2: tie 3/0 and 5/1; 3: sparse pulses, at most one per window.
  function automatic logic [9:0] model_d0();
    logic [9:0] w;
    w = 10'h000;
    case (mode)
      1: if (phase == 4'd7 && pll_delay == 4'd1 && cyc[0]) w = 10'h2AB;
      2: begin
        if (phase == 4'd3 && pll_delay == 4'd0 && cyc[0]) w = 10'h354;
        if (phase == 4'd5 && pll_delay == 4'd1 && cyc[0]) w = 10'h0AB;
      end
      3: if (cyc[4:0] == 5'd0) w = 10'h154;
      default: w = 10'h000;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    d0 = manual ? man_d0 : model_d0();
  endtask

  task automatic do_reset(input logic lock);
    reset_n    = 1'b0;
    pll_locked = lock;
    manual     = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  task automatic wait_aligned(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!aligned && n < 1000);
  endtask

  function automatic logic [22:0] outs();
    return {phase, pll_delay, aligned, scanning, best_score, rescans};
  endfunction

  initial begin
    int n;
    int bad;
    logic seen;

    // Reset and idle with the PLL unlocked
    reset_n = 1'b0;
    pll_locked = 1'b0;
    repeat (3) step();
    chk("reset_outs", 32'(outs()), 32'd0);
    reset_n = 1'b1;
    bad = 0;
    repeat (100) begin
      step();
      if (outs() != 23'd0) bad++;
    end
    chk("idle_hold", 32'(bad), 32'd0);
    $display("test idle: checks=%0d errors=%0d", checks, errors);

    // Single good setting at phase 7 / delay 1
    mode = 1;
    do_reset(1'b1);
    step();
    chk("scan_scanning", 32'(scanning), 32'd1);
    wait_aligned(n);
    chk("good_cycles", 32'(n), 32'd425);
    chk("good_phase", 32'(phase), 32'd7);
    chk("good_delay", 32'(pll_delay), 32'd1);
    chk("good_score", 32'(best_score), 32'd8);
    chk("good_aligned", 32'(aligned), 32'd1);
    chk("good_rescans", 32'(rescans), 32'd0);
    chk("good_scanning", 32'(scanning), 32'd0);
    $display("test single_good: n=%0d phase=%0d delay=%0d score=%0d", n, phase, pll_delay, best_score);

    // Loss in TRACK: a hit landing on the terminal count keeps lock, 64 silent cycles lose it
    manual = 1'b1;
    man_d0 = 10'h2AB;
    step();
    man_d0 = 10'h000;
    repeat (63) step();
    man_d0 = 10'h2AB;
    step();
    man_d0 = 10'h000;
    step();
    step();
    chk("hit_at_terminal", 32'(aligned), 32'd1);
    repeat (63) step();
    chk("loss_before", 32'(aligned), 32'd1);
    step();
    chk("loss_aligned", 32'(aligned), 32'd0);
    chk("loss_rescans", 32'(rescans), 32'd1);
    chk("loss_scanning", 32'(scanning), 32'd0);
    chk("loss_phase", 32'(phase), 32'd0);
    chk("loss_score_held", 32'(best_score), 32'd8);
    step();
    chk("loss_rescan", 32'(scanning), 32'd1);
    $display("test loss: rescans=%0d", rescans);

    // Tie: 3/0 and 5/1 both score 8, earlier one wins
    mode = 2;
    do_reset(1'b1);
    wait_aligned(n);
    chk("tie_cycles", 32'(n), 32'd426);
    chk("tie_phase", 32'(phase), 32'd3);
    chk("tie_delay", 32'(pll_delay), 32'd0);
    chk("tie_score", 32'(best_score), 32'd8);
    $display("test tie: phase=%0d delay=%0d", phase, pll_delay);

    // Failed scan: best score never reaches MIN_HITS
    mode = 3;
    do_reset(1'b1);
    n = 0;
    seen = 1'b0;
    do begin
      step();
      n++;
      if (aligned) seen = 1'b1;
    end while (rescans == 8'd0 && n < 1000);
    chk("fail_cycles", 32'(n), 32'd422);
    chk("fail_rescans", 32'(rescans), 32'd1);
    chk("fail_never_aligned", 32'(seen), 32'd0);
    chk("fail_scanning", 32'(scanning), 32'd0);
    chk("fail_score", 32'(best_score), 32'd0);
    step();
    chk("fail_restart_scan", 32'(scanning), 32'd1);
    chk("fail_restart_phase", 32'(phase), 32'd0);
    chk("fail_restart_delay", 32'(pll_delay), 32'd0);
    repeat (21) step();
    chk("fail_next_phase", 32'(phase), 32'd1);
    $display("test failed_scan: n=%0d rescans=%0d", n, rescans);

    // Lock drop mid-MEASURE of setting 2, then relock and full rescan
    mode = 1;
    do_reset(1'b1);
    repeat (50) step();
    chk("drop_pre_phase", 32'(phase), 32'd2);
    chk("drop_pre_scanning", 32'(scanning), 32'd1);
    pll_locked = 1'b0;
    step();
    chk("drop_phase", 32'(phase), 32'd0);
    chk("drop_delay", 32'(pll_delay), 32'd0);
    chk("drop_scanning", 32'(scanning), 32'd0);
    chk("drop_rescans", 32'(rescans), 32'd0);
    pll_locked = 1'b1;
    wait_aligned(n);
    chk("relock_cycles", 32'(n), 32'd426);
    chk("relock_phase", 32'(phase), 32'd7);
    chk("relock_delay", 32'(pll_delay), 32'd1);
    $display("test lock_drop: n=%0d phase=%0d delay=%0d", n, phase, pll_delay);

    // Asynchronous reset mid-TRACK, away from any clock edge
    repeat (5) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'd0);
    $display("test async_reset: outs=%0h", outs());
    step();
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
